// File: rtl/fc_stream_feeder.sv
// Sequencer feeding fully_connected_core: streams node/weight pairs per neuron,
// drains the core pipeline and writes quantized results. Saturation: FC_FEEDER_SAT_EN.
module fc_stream_feeder #(
  parameter int DATA_WIDTH    = 8,
  parameter int IN_CNT_WIDTH  = 10,
  parameter int OUT_CNT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int SHIFT         = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start,
  input  logic [IN_CNT_WIDTH-1:0]   i_num_in,
  input  logic [OUT_CNT_WIDTH-1:0]  i_num_out,
  output logic                      o_idle,
  output logic                      o_done,
  output logic                      o_node_ce,
  output logic [ADDR_WIDTH-1:0]     o_node_addr,
  input  logic [DATA_WIDTH-1:0]     i_node_rdata,
  output logic                      o_wegt_ce,
  output logic [ADDR_WIDTH-1:0]     o_wegt_addr,
  input  logic [DATA_WIDTH-1:0]     i_wegt_rdata,
  output logic                      o_core_run,
  output logic                      o_core_valid,
  output logic [DATA_WIDTH-1:0]     o_core_node,
  output logic [DATA_WIDTH-1:0]     o_core_wegt,
  input  logic                      i_core_valid,
  input  logic [4*DATA_WIDTH-1:0]   i_core_result,
  output logic                      o_res_we,
  output logic [OUT_CNT_WIDTH-1:0]  o_res_addr,
  output logic [DATA_WIDTH-1:0]     o_res_data
);

  localparam int RW = 4 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, RUN, FEED, DRAIN, WRITE, DONE
  } state_t;

  state_t state, state_nx;

  logic [IN_CNT_WIDTH-1:0]  n_q;
  logic [IN_CNT_WIDTH-1:0]  in_idx;
  logic [IN_CNT_WIDTH-1:0]  ret_cnt;
  logic [OUT_CNT_WIDTH-1:0] m_q;
  logic [OUT_CNT_WIDTH-1:0] out_idx;
  logic [ADDR_WIDTH-1:0]    wptr;
  logic [RW-1:0]            cap;
  logic                     vld_q;
  logic                     last_in;
  logic                     last_ret;
  logic                     last_out;
  logic                     ret_cnt_en;
  logic [DATA_WIDTH-1:0]    quant;

  assign last_in  = (in_idx == n_q - IN_CNT_WIDTH'(1));
  assign last_ret = i_core_valid &&
                    (ret_cnt + IN_CNT_WIDTH'(1) == n_q);
  assign last_out = ({1'b0, out_idx} + (OUT_CNT_WIDTH+1)'(1))
                    == {1'b0, m_q};
  assign ret_cnt_en = i_core_valid &&
                      (state != IDLE) && (state != RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_start)
          state_nx = (i_num_out == '0) ? DONE : RUN;
      end
      RUN:   state_nx = (n_q == '0) ? WRITE : FEED;
      FEED:  if (last_in) state_nx = DRAIN;
      DRAIN: if (last_ret) state_nx = WRITE;
      WRITE: state_nx = last_out ? DONE : RUN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q     <= '0;
      m_q     <= '0;
      in_idx  <= '0;
      ret_cnt <= '0;
      out_idx <= '0;
      wptr    <= '0;
      cap     <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= (state == FEED);
      if (state == IDLE && i_start) begin
        n_q     <= i_num_in;
        m_q     <= i_num_out;
        out_idx <= '0;
        wptr    <= '0;
      end
      if (state == RUN) begin
        in_idx  <= '0;
        ret_cnt <= '0;
        cap     <= '0;
      end else if (ret_cnt_en) begin
        ret_cnt <= ret_cnt + IN_CNT_WIDTH'(1);
      end
      if (state == FEED) begin
        in_idx <= in_idx + IN_CNT_WIDTH'(1);
        wptr   <= wptr + ADDR_WIDTH'(1);
      end
      if (state == DRAIN && last_ret)
        cap <= i_core_result;
      if (state == WRITE)
        out_idx <= out_idx + OUT_CNT_WIDTH'(1);
    end
  end

`ifdef FC_FEEDER_SAT_EN
  logic [RW-1:0] shifted;
  assign shifted = cap >> SHIFT;
  assign quant = (|shifted[RW-1:DATA_WIDTH]) ? '1
               : shifted[DATA_WIDTH-1:0];
`else
  assign quant = DATA_WIDTH'(cap >> SHIFT);
`endif

  assign o_idle       = (state == IDLE);
  assign o_done       = (state == DONE);
  assign o_node_ce    = (state == FEED);
  assign o_wegt_ce    = (state == FEED);
  assign o_node_addr  = o_node_ce ? ADDR_WIDTH'(in_idx) : '0;
  assign o_wegt_addr  = o_wegt_ce ? wptr : '0;
  assign o_core_run   = (state == RUN);
  assign o_core_valid = vld_q;
  // Operands are gated so idle cycles present zeros, not stale read data.
  assign o_core_node  = vld_q ? i_node_rdata : '0;
  assign o_core_wegt  = vld_q ? i_wegt_rdata : '0;
  assign o_res_we     = (state == WRITE);
  assign o_res_addr   = o_res_we ? out_idx : '0;
  assign o_res_data   = o_res_we ? quant : '0;

endmodule

// File: tb/tb_fc_stream_feeder.sv
// Bench for fc_stream_feeder: memories, a core model and a sum-of-products
// reference; honours FC_FEEDER_SAT_EN for expected quantization.
module tb_fc_stream_feeder;

  localparam int DW  = 8;
  localparam int ICW = 10;
  localparam int OCW = 8;
  localparam int AW  = 16;
  localparam int SH  = 0;

  logic           clk;
  logic           reset_n;
  logic           i_start;
  logic [ICW-1:0] i_num_in;
  logic [OCW-1:0] i_num_out;
  logic           o_idle, o_done;
  logic           o_node_ce, o_wegt_ce;
  logic [AW-1:0]  o_node_addr, o_wegt_addr;
  logic [DW-1:0]  node_rdata, wegt_rdata;
  logic           o_core_run, o_core_valid;
  logic [DW-1:0]  o_core_node, o_core_wegt;
  logic           core_valid;
  logic [4*DW-1:0] core_result;
  logic           o_res_we;
  logic [OCW-1:0] o_res_addr;
  logic [DW-1:0]  o_res_data;

  fc_stream_feeder #(
    .DATA_WIDTH(DW), .IN_CNT_WIDTH(ICW), .OUT_CNT_WIDTH(OCW),
    .ADDR_WIDTH(AW), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_num_in(i_num_in), .i_num_out(i_num_out),
    .o_idle(o_idle), .o_done(o_done),
    .o_node_ce(o_node_ce), .o_node_addr(o_node_addr),
    .i_node_rdata(node_rdata),
    .o_wegt_ce(o_wegt_ce), .o_wegt_addr(o_wegt_addr),
    .i_wegt_rdata(wegt_rdata),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_valid(core_valid), .i_core_result(core_result),
    .o_res_we(o_res_we), .o_res_addr(o_res_addr),
    .o_res_data(o_res_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] node_mem [0:65535];
  logic [7:0] wegt_mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (o_node_ce) node_rdata <= node_mem[o_node_addr];
    if (o_wegt_ce) wegt_rdata <= wegt_mem[o_wegt_addr];
  end

  // Core model: product stage then accumulate stage, valid two cycles later.
  logic [31:0] p1, acc;
  logic        v1, v2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1 <= 0; acc <= 0; v1 <= 0; v2 <= 0;
    end else begin
      v1 <= o_core_valid;
      p1 <= 32'(o_core_node) * 32'(o_core_wegt);
      v2 <= v1;
      if (o_core_run) acc <= 0;
      else if (v1)    acc <= acc + p1;
    end
  end
  assign core_valid  = v2;
  assign core_result = acc;

  logic [OCW-1:0] wr_addr [$];
  logic [DW-1:0]  wr_data [$];
  logic [AW-1:0]  node_q [$];
  logic [AW-1:0]  wegt_q [$];
  int runs, clash, ce_mis;

  always @(negedge clk) begin
    if (reset_n) begin
      if (o_res_we) begin
        wr_addr.push_back(o_res_addr);
        wr_data.push_back(o_res_data);
      end
      if (o_core_run) runs++;
      if (o_node_ce) begin
        node_q.push_back(o_node_addr);
        wegt_q.push_back(o_wegt_addr);
      end
      if (o_node_ce != o_wegt_ce) ce_mis++;
      if (o_core_run && (o_core_valid || v1 || v2)) clash++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] quant(input logic [63:0] v);
    logic [63:0] s;
    s = v >> SH;
`ifdef FC_FEEDER_SAT_EN
    return (s > 64'd255) ? 8'hFF : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  function automatic logic [63:0] ref_sum(input int n, input int k);
    logic [63:0] s = 0;
    for (int i = 0; i < n; i++)
      s += 64'(node_mem[i]) * 64'(wegt_mem[k*n+i]);
    return s;
  endfunction

  task automatic run_job(input int n, input int m, input bit inject);
    int s_cyc, k, exp_done, nerr, werr;
    bit got;
    wr_addr.delete(); wr_data.delete();
    node_q.delete(); wegt_q.delete();
    runs = 0; clash = 0; ce_mis = 0;
    @(negedge clk);
    i_start = 1; i_num_in = ICW'(n); i_num_out = OCW'(m);
    s_cyc = cyc;
    @(negedge clk);
    i_start = 0;
    k = 0; got = 0;
    while (k < 5000) begin
      if (o_done) begin got = 1; break; end
      i_start = (inject && k == 2);
      @(negedge clk);
      k++;
    end
    i_start = 0;
    chk("done_seen", 64'(got), 1);
    exp_done = (m == 0) ? s_cyc + 1
             : (n == 0) ? s_cyc + 1 + 2*m
             : s_cyc + 1 + m*(n+5);
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("write_count", 64'(wr_addr.size()), 64'(m));
    for (int j = 0; j < m && j < wr_addr.size(); j++) begin
      chk("write_addr", 64'(wr_addr[j]), 64'(j));
      chk("write_data", 64'(wr_data[j]), 64'(quant(ref_sum(n, j))));
    end
    chk("run_pulses", 64'(runs), 64'(m));
    chk("read_count", 64'(node_q.size()), 64'(m*n));
    nerr = 0; werr = 0;
    for (int j = 0; j < node_q.size(); j++) begin
      if (node_q[j] != AW'(j % n)) nerr++;
      if (wegt_q[j] != AW'(j)) werr++;
    end
    chk("node_addr_seq", 64'(nerr), 0);
    chk("wegt_addr_seq", 64'(werr), 0);
    chk("ce_match", 64'(ce_mis), 0);
    chk("run_clash", 64'(clash), 0);
    @(negedge clk);
    chk("idle_after", 64'(o_idle), 1);
    chk("done_pulse", 64'(o_done), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_idle"}, 64'(o_idle), 1);
    chk({tag, "_outs"},
        64'({o_done, o_node_ce, o_wegt_ce, o_core_run,
             o_core_valid, o_res_we}), 0);
    chk({tag, "_buses"},
        64'({o_node_addr, o_wegt_addr, o_core_node,
             o_core_wegt, o_res_addr, o_res_data}), 0);
  endtask

  initial begin
    int n, m;
    reset_n = 0; i_start = 0; i_num_in = 0; i_num_out = 0;
    node_rdata = 8'hA5; wegt_rdata = 8'h5A;
    for (int i = 0; i < 65536; i++) begin
      node_mem[i] = 0; wegt_mem[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check_quiet("post_reset");

    for (int i = 0; i < 4; i++) begin
      node_mem[i] = 8'(i + 1);
      wegt_mem[i] = 8'(i + 5);
      wegt_mem[i+4] = 8'd1;
    end
    run_job(4, 1, 0);
    chk("basic_70", 64'(wr_data.size() > 0 ? wr_data[0] : 0), 70);
    run_job(4, 2, 0);
    chk("second_10", 64'(wr_data.size() > 1 ? wr_data[1] : 0), 10);

    for (int i = 0; i < 4; i++) begin
      node_mem[i] = 8'hFF; wegt_mem[i] = 8'hFF;
    end
    run_job(4, 1, 0);
`ifdef FC_FEEDER_SAT_EN
    chk("big_sat", 64'(wr_data.size() > 0 ? wr_data[0] : 0), 255);
`else
    chk("big_wrap", 64'(wr_data.size() > 0 ? wr_data[0] : 0), 4);
`endif

    run_job(0, 0, 0);
    run_job(5, 0, 0);
    run_job(0, 2, 0);

    for (int i = 0; i < 8; i++) begin
      node_mem[i] = 8'($urandom); wegt_mem[i] = 8'($urandom);
    end
    run_job(8, 1, 1);

    @(negedge clk);
    i_start = 1; i_num_in = 8; i_num_out = 1;
    @(negedge clk);
    i_start = 0;
    repeat (3) @(negedge clk);
    chk("midfeed_ce", 64'(o_node_ce), 1);
    reset_n = 0;
    #1 check_quiet("midfeed_reset");
    @(negedge clk);
    reset_n = 1;
    run_job(4, 1, 0);

    for (int t = 0; t < 10; t++) begin
      n = (t == 9) ? 40 : int'($urandom_range(1, 12));
      m = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) node_mem[i] = 8'($urandom);
      for (int i = 0; i < n*m; i++) wegt_mem[i] = 8'($urandom);
      run_job(n, m, t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
